// File: rtl/pea_exec_ctrl.sv
// PEA execution controller: steps the PEA through K configurations
// N times, drains the pipeline, then pulses done back to the K controller.
module pea_exec_ctrl #(
   parameter int N_CFG     = 16,
   parameter int CNT_W     = 16,
   parameter int DRAIN_CYC = 5
) (
   input  logic                     clk_i,
   input  logic                     rst_n_i,
   input  logic                     start_i,
   input  logic [$clog2(N_CFG)-1:0] k_last_i,
   input  logic [CNT_W-1:0]         n_iter_i,
   input  logic                     abort_i,
   output logic [$clog2(N_CFG)-1:0] cfg_idx_o,
   output logic                     cfg_valid_o,
   output logic [CNT_W-1:0]         iter_o,
   output logic                     busy_o,
   output logic                     done_o
);

   localparam int IW = $clog2(N_CFG);
   localparam int DW = (DRAIN_CYC > 0) ? $clog2(DRAIN_CYC + 1) : 1;
   localparam logic [DW-1:0] DRAIN_LD =
      DW'((DRAIN_CYC > 0) ? DRAIN_CYC - 1 : 0);

   typedef enum logic [1:0] {
      S_IDLE,
      S_RUN,
      S_DRAIN,
      S_DONE
   } state_e;

   state_e           state_q, state_d;
   logic [IW-1:0]    idx_q, idx_d;
   logic [CNT_W-1:0] iter_q, iter_d;
   logic [IW-1:0]    klast_q, klast_d;
   logic [CNT_W-1:0] niter_q, niter_d;
   logic [DW-1:0]    dcnt_q, dcnt_d;
   logic             valid_q, busy_q, done_q;

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      iter_d  = iter_q;
      klast_d = klast_q;
      niter_d = niter_q;
      dcnt_d  = dcnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (start_i) begin
               klast_d = k_last_i;
               niter_d = n_iter_i;
               idx_d   = '0;
               iter_d  = '0;
               state_d = (n_iter_i == '0) ? S_DONE : S_RUN;
            end
         end
         S_RUN: begin
            // terminal compare comes first, so iter never wraps
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (idx_q != klast_q) begin
               idx_d = idx_q + IW'(1);
            end else if (iter_q != niter_q - CNT_W'(1)) begin
               idx_d  = '0;
               iter_d = iter_q + CNT_W'(1);
            end else if (DRAIN_CYC == 0) begin
               state_d = S_DONE;
            end else begin
               dcnt_d  = DRAIN_LD;
               state_d = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (abort_i) begin
               state_d = S_IDLE;
            end else if (dcnt_q == '0) begin
               state_d = S_DONE;
            end else begin
               dcnt_d = dcnt_q - DW'(1);
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         iter_q  <= '0;
         klast_q <= '0;
         niter_q <= '0;
         dcnt_q  <= '0;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         iter_q  <= iter_d;
         klast_q <= klast_d;
         niter_q <= niter_d;
         dcnt_q  <= dcnt_d;
         valid_q <= (state_d == S_RUN);
         busy_q  <= (state_d != S_IDLE);
         done_q  <= (state_d == S_DONE);
      end
   end

   assign cfg_idx_o   = idx_q;
   assign iter_o      = iter_q;
   assign cfg_valid_o = valid_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;

endmodule

// File: tb/tb_pea_exec_ctrl.sv
// Bench for pea_exec_ctrl: default build plus a small DRAIN_CYC=0 build,
// both checked each cycle against a job-timeline reference model.
module tb_pea_exec_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        start;
   logic        abort;
   logic [3:0]  k_last;
   logic [15:0] n_iter;

   logic [3:0]  idx0;
   logic [15:0] iter0;
   logic        valid0, busy0, done0;
   logic [1:0]  idx1;
   logic [3:0]  iter1;
   logic        valid1, busy1, done1;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   always #5 clk = ~clk;

   pea_exec_ctrl u_dut0 (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .start_i     (start),
      .k_last_i    (k_last),
      .n_iter_i    (n_iter),
      .abort_i     (abort),
      .cfg_idx_o   (idx0),
      .cfg_valid_o (valid0),
      .iter_o      (iter0),
      .busy_o      (busy0),
      .done_o      (done0)
   );

   pea_exec_ctrl #(
      .N_CFG     (4),
      .CNT_W     (4),
      .DRAIN_CYC (0)
   ) u_dut1 (
      .clk_i       (clk),
      .rst_n_i     (rst_n),
      .start_i     (start),
      .k_last_i    (k_last[1:0]),
      .n_iter_i    (n_iter[3:0]),
      .abort_i     (abort),
      .cfg_idx_o   (idx1),
      .cfg_valid_o (valid1),
      .iter_o      (iter1),
      .busy_o      (busy1),
      .done_o      (done1)
   );

   // One accepted job: start cycle, kernel length, repetitions, drain length
   typedef struct {
      bit act;
      int ts;
      int k;
      int n;
      int d;
   } mdl_t;

   mdl_t m0, m1;

   function automatic void expv(input mdl_t m, input int c,
                                output bit v, output bit b, output bit d,
                                output int ix, output int it);
      int off, kn, dd;
      v = 0; b = 0; d = 0; ix = 0; it = 0;
      if (m.act) begin
         off = c - m.ts;
         kn  = m.k * m.n;
         dd  = (m.n == 0) ? 0 : m.d;
         b   = 1;
         if (off >= 1 && off <= kn) begin
            v  = 1;
            ix = (off - 1) % m.k;
            it = (off - 1) / m.k;
         end else if (off == kn + dd + 1) begin
            d = 1;
         end
      end
   endfunction

   function automatic mdl_t upd(input mdl_t m, input int c, input bit st,
                                input bit ab, input int kl, input int ni);
      mdl_t r;
      int off, dd;
      r = m;
      if (!r.act) begin
         if (st) begin
            r.act = 1;
            r.ts  = c;
            r.k   = kl + 1;
            r.n   = ni;
         end
      end else begin
         off = c - r.ts;
         dd  = (r.n == 0) ? 0 : r.d;
         if (off == r.k * r.n + dd + 1) r.act = 0;
         else if (ab) r.act = 0;
      end
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h cyc=%0d",
                tag, obs, exp, cyc);
      end
   endtask

   task automatic chk_all();
      bit v, b, d;
      int ix, it;
      expv(m0, cyc, v, b, d, ix, it);
      chk("d0_valid", 32'(valid0), 32'(v));
      chk("d0_busy", 32'(busy0), 32'(b));
      chk("d0_done", 32'(done0), 32'(d));
      if (v) begin
         chk("d0_idx", 32'(idx0), 32'(ix));
         chk("d0_iter", 32'(iter0), 32'(it));
      end
      expv(m1, cyc, v, b, d, ix, it);
      chk("d1_valid", 32'(valid1), 32'(v));
      chk("d1_busy", 32'(busy1), 32'(b));
      chk("d1_done", 32'(done1), 32'(d));
      if (v) begin
         chk("d1_idx", 32'(idx1), 32'(ix));
         chk("d1_iter", 32'(iter1), 32'(it));
      end
   endtask

   task automatic tick();
      @(posedge clk);
      if (!rst_n) begin
         m0.act = 0;
         m1.act = 0;
      end else begin
         m0 = upd(m0, cyc, start, abort, int'(k_last), int'(n_iter));
         m1 = upd(m1, cyc, start, abort, int'(k_last[1:0]),
                  int'(n_iter[3:0]));
      end
      cyc++;
      #1;
      chk_all();
      start = 1'b0;
      abort = 1'b0;
   endtask

   task automatic go(input int kl, input int ni);
      start  = 1'b1;
      k_last = 4'(kl);
      n_iter = 16'(ni);
      tick();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) tick();
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      m0.act = 0;
      m1.act = 0;
      #1;
      chk("rst_idx0", 32'(idx0), 32'd0);
      chk("rst_iter0", 32'(iter0), 32'd0);
      chk("rst_idx1", 32'(idx1), 32'd0);
      chk("rst_iter1", 32'(iter1), 32'd0);
      chk_all();
      idle(2);
      rst_n = 1'b1;
   endtask

   initial begin
      int t0, td0, td1;
      m0 = '{act: 0, ts: 0, k: 1, n: 0, d: 5};
      m1 = '{act: 0, ts: 0, k: 1, n: 0, d: 0};
      rst_n  = 1'b1;
      start  = 1'b0;
      abort  = 1'b0;
      k_last = '0;
      n_iter = '0;
      #2;
      do_reset();
      idle(3);

      // worked example: K=4, N=2
      t0 = cyc;
      td0 = -1;
      td1 = -1;
      go(3, 2);
      for (int i = 0; i < 40; i++) begin
         if (done0 && td0 < 0) td0 = cyc;
         if (done1 && td1 < 0) td1 = cyc;
         if (td0 >= 0 && td1 >= 0) break;
         tick();
      end
      chk("ex_done_t_d0", 32'(td0 - t0), 32'd14);
      chk("ex_done_t_d1", 32'(td1 - t0), 32'd9);
      idle(2);

      // zero repetitions
      t0 = cyc;
      go(5, 0);
      chk("n0_done0", 32'(done0), 32'd1);
      chk("n0_valid0", 32'(valid0), 32'd0);
      idle(3);

      // single-configuration kernel
      go(0, 4);
      idle(12);

      // second start while running is ignored
      go(2, 3);
      idle(2);
      go(7, 9);
      idle(20);

      // abort in third RUN cycle, then a clean restart
      go(3, 3);
      idle(2);
      abort = 1'b1;
      tick();
      chk("ab_valid0", 32'(valid0), 32'd0);
      chk("ab_busy0", 32'(busy0), 32'd0);
      go(2, 1);
      chk("ab_restart_idx0", 32'(idx0), 32'd0);
      idle(12);

      // reset in the middle of DRAIN
      go(1, 1);
      idle(3);
      do_reset();
      go(1, 2);
      idle(15);

      // randomized traffic
      for (int i = 0; i < 2500; i++) begin
         start  = ($urandom_range(0, 3) == 0);
         abort  = ($urandom_range(0, 39) == 0);
         k_last = 4'($urandom_range(0, 15));
         if ($urandom_range(0, 7) == 0) n_iter = 16'($urandom_range(0, 20));
         else n_iter = 16'($urandom_range(0, 4));
         tick();
      end
      idle(400);

      // largest legal repetition count on the default build
      go(0, 65535);
      for (int i = 0; i < 70000 && m0.act; i++) tick();
      chk("big_idle_busy0", 32'(busy0), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pea_exec_ctrl.md
PEA_EXEC_CTRL -- requirements
Module: pea_exec_ctrl

Interface
REQ-001 The module SHALL have parameter N_CFG, default 16, giving the number of configuration slots and a power of two >= 2.
REQ-002 The module SHALL have parameter CNT_W, default 16, giving the iteration counter width.
REQ-003 The module SHALL have parameter DRAIN_CYC, default 5, giving the pipeline drain cycles after the last kernel cycle; 0 is legal.
REQ-004 clk_i  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n_i  input  1  reset, asynchronous, active-low.
REQ-006 start_i  input  1  single-cycle kernel start pulse from the K controller (its delayed start output).
REQ-007 k_last_i  input  $clog2(N_CFG)  last configuration index of the kernel (kernel length K = k_last_i+1); sampled only on accepted start.
REQ-008 n_iter_i  input  CNT_W  number of kernel repetitions; sampled only on accepted start.
REQ-009 abort_i  input  1  synchronous abort of the current execution.
REQ-010 cfg_idx_o  output  $clog2(N_CFG)  configuration index presented to the PEA.
REQ-011 cfg_valid_o  output  1  PEA execute enable; cfg_idx_o is meaningful only when high.
REQ-012 iter_o  output  CNT_W  index of the repetition currently executing.
REQ-013 busy_o  output  1  high in any state other than IDLE.
REQ-014 done_o  output  1  single-cycle completion pulse back to the controller.

Function
REQ-015 The FSM SHALL have exactly four states (IDLE, RUN, DRAIN, DONE), and all outputs SHALL be registered.
REQ-016 IDLE, start_i=1, n_iter_i!=0: latch k_last_i/n_iter_i; next cycle RUN with cfg_idx_o=0, iter_o=0, cfg_valid_o=1.
REQ-017 IDLE, start_i=1, n_iter_i=0: next cycle DONE; cfg_valid_o never asserts.
REQ-018 start_i outside IDLE SHALL be ignored; latched k_last/n_iter SHALL not change.
REQ-019 RUN, cfg_idx_o<k_last: cfg_idx_o increments by 1.
REQ-020 RUN, cfg_idx_o==k_last and iter_o<n_iter-1: cfg_idx_o wraps to 0 and iter_o increments by 1.
REQ-021 RUN, cfg_idx_o==k_last and iter_o==n_iter-1: enter DRAIN (or DONE if DRAIN_CYC=0); cfg_valid_o=0 and cfg_idx_o, iter_o hold their last values.
REQ-022 k_last=0: cfg_idx_o stays 0 and iter_o increments every RUN cycle.
REQ-023 DRAIN SHALL last exactly DRAIN_CYC cycles, using a down-counter, then enter DONE.
REQ-024 DONE SHALL assert done_o for exactly one cycle, then return to IDLE; busy_o SHALL drop in the same cycle as the return to IDLE.
REQ-025 Timing: start_i at cycle t gives cfg_valid_o high for cycles t+1..t+K*N and done_o at cycle t+K*N+DRAIN_CYC+1.
REQ-026 abort_i in RUN or DRAIN: next cycle IDLE with cfg_valid_o=0 and no done_o pulse; abort_i has priority over every RUN/DRAIN transition.
REQ-027 abort_i in IDLE or DONE SHALL have no effect; a DONE pulse is never suppressed.
REQ-028 iter_o arithmetic SHALL be unsigned CNT_W and SHALL never wrap, because the terminal compare precedes any increment; n_iter=2^CNT_W-1 is legal.

Reset
REQ-029 While rst_n_i=0: state=IDLE; cfg_idx_o=0, cfg_valid_o=0, iter_o=0, busy_o=0, done_o=0; latched parameters and drain counter=0.
REQ-030 Reset asserted mid-RUN or mid-DRAIN SHALL abandon execution immediately with no done_o pulse, and the block SHALL accept the first start_i pulse after deassertion.

Verification
REQ-031 k_last=3, n_iter=2, start at t=10: cfg_idx 0,1,2,3,0,1,2,3 on t=11..18; iter 0 on t=11..14 and 1 on t=15..18; done_o at t=24.
REQ-032 n_iter=0, start at t=5: done_o at t=6; cfg_valid_o stays 0 throughout.
REQ-033 k_last=0, n_iter=4: cfg_idx_o=0 with iter 0..3 over 4 cycles; DRAIN lasts 5 cycles, then a single done_o pulse.
REQ-034 Second start_i pulse during RUN with different k_last/n_iter: ignored; sequence and done_o timing identical to the single-start case.
REQ-035 abort_i in the third RUN cycle: cfg_valid_o=0 and busy_o=0 next cycle, no done_o; a following start runs correctly from idx 0.
REQ-036 rst_n_i pulsed low mid-DRAIN: all outputs 0 immediately, no done_o; DRAIN_CYC=0 build gives done_o at t+K*N+1.
